instr_fetch_unit: RTL

Instruction fetch unit for the RV32I core. It owns the architectural PC, issues one instruction-memory request at a time over a valid/ready request and valid response interface, and presents the fetched word to decode. It consumes the address builder's `pc_sel`/`pc_AB` to choose the next PC: hold, sequential, or arbitrary target for jumps and taken branches.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/fetch_timeout_ctr.sv | 23 ++
 rtl/instr_fetch_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I constants: PC select codes, NOP encoding and base opcodes
// used by the fetch unit and the address builder.
package riscv_pkg;

   localparam logic [1:0]  PC_HOLD   = 2'b00;
   localparam logic [1:0]  PC_4      = 2'b01;
   localparam logic [1:0]  PC_ARB    = 2'b10;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0]  OP_LUI    = 7'b0110111;
   localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [6:0]  OP_JALR   = 7'b1100111;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;
   localparam logic [6:0]  OP_IMM    = 7'b0010011;
   localparam logic [6:0]  OP_REG    = 7'b0110011;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Clearable 8-bit up-counter; o_tmo flags when the count equals LIMIT.
module fetch_timeout_ctr #(
   parameter logic [7:0] LIMIT = 8'd255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tmo
);

   logic [7:0] r_cnt;

   // Saturates so a stuck enable can never wrap back below LIMIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       r_cnt <= 8'd0;
      else if (i_clr)                   r_cnt <= 8'd0;
      else if (i_en && r_cnt != 8'hFF)  r_cnt <= r_cnt + 8'd1;
   end

   assign o_tmo = (r_cnt == LIMIT);

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch: owns the PC, issues one imem request at a time
// and presents the fetched word to decode. All outputs are registered.
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        upd_en,
   input  logic [1:0]  pc_sel,
   input  logic [31:0] pc_AB,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        misalign_fault,
   output logic        bus_fault
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID, S_FAULT} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic [31:0] r_instr, w_instr_nxt;
   logic        r_misalign, w_misalign_nxt;
   logic        r_bus, w_bus_nxt;
   logic        r_req_valid, r_instr_valid;
   logic        w_ctr_clr, w_ctr_en, w_tmo;

   fetch_timeout_ctr #(.LIMIT(8'(TIMEOUT))) u_tmo (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (w_ctr_clr),
      .i_en  (w_ctr_en),
      .o_tmo (w_tmo)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_instr_nxt    = r_instr;
      w_misalign_nxt = r_misalign;
      w_bus_nxt      = r_bus;
      w_ctr_clr      = 1'b0;
      w_ctr_en       = 1'b0;
      case (r_state)
         // Handshake needs the registered valid, so nothing is accepted
         // on the first edge after reset release.
         S_REQ: begin
            if (r_req_valid && imem_req_ready) begin
               w_state_nxt = S_WAIT;
               w_ctr_clr   = 1'b1;
            end
         end
         S_WAIT: begin
            w_ctr_en = 1'b1;
            if (imem_rsp_valid) begin
               if (imem_rsp_err) begin
                  w_bus_nxt   = 1'b1;
                  w_state_nxt = S_FAULT;
               end else begin
                  w_instr_nxt = imem_rsp_data;
                  w_state_nxt = S_VALID;
               end
            end else if (w_tmo) begin
               w_bus_nxt   = 1'b1;
               w_state_nxt = S_FAULT;
            end
         end
         S_VALID: begin
            if (upd_en) begin
               case (pc_sel)
                  PC_HOLD: ;
                  PC_ARB: begin
                     if (pc_AB[1:0] != 2'b00) begin
                        w_misalign_nxt = 1'b1;
                        w_state_nxt    = S_FAULT;
                     end else begin
                        w_pc_nxt    = pc_AB;
                        w_state_nxt = S_REQ;
                     end
                  end
                  default: begin
                     w_pc_nxt    = r_pc + 32'd4;
                     w_state_nxt = S_REQ;
                  end
               endcase
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_REQ;
         r_pc          <= RESET_PC;
         r_instr       <= NOP_INSTR;
         r_misalign    <= 1'b0;
         r_bus         <= 1'b0;
         r_req_valid   <= 1'b0;
         r_instr_valid <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_instr       <= w_instr_nxt;
         r_misalign    <= w_misalign_nxt;
         r_bus         <= w_bus_nxt;
         r_req_valid   <= (w_state_nxt == S_REQ);
         r_instr_valid <= (w_state_nxt == S_VALID);
      end
   end

   assign imem_req_valid = r_req_valid;
   assign imem_addr      = r_pc;
   assign pc             = r_pc;
   assign instr          = r_instr;
   assign instr_valid    = r_instr_valid;
   assign misalign_fault = r_misalign;
   assign bus_fault      = r_bus;

endmodule
